clk_div_multi: RTL and testbench

Multi-channel programmable clock divider. Produces `N_CH` independent divided clocks, each with 50 % duty cycle for both even and odd divisors, plus a one-cycle tick strobe per channel. Divisor changes are shadowed and take effect only at a period boundary, so every divisor change is glitch-free. The block sits beside the clock/reset logic and feeds peripheral clocks and clock enables (UART, SPI, PWM, timers).

---
 rtl/clk_div_pkg.sv | 34 +++
 rtl/clk_div_multi_if.sv | 38 +++
 rtl/clk_div_ch.sv | 107 ++++++++++
 rtl/clk_div_multi.sv | 46 ++++
 tb/tb_clk_div_multi.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/clk_div_pkg.sv
// ---------------------------------------------------------------------------
// clk_div_pkg
// Shared definitions for the multi-channel clock divider.
//   DEFAULT_WIDTH : default divisor/counter width per channel
//   DIV_STOP      : divisor value that stops a channel
//   DIV_TICK      : divisor value that gives a tick strobe on every cycle
//   ch_mode_e     : channel operating mode decoded from the divisor
//   half_period() : ceil(d/2), the number of posedge cycles o_clk's flop is high
//   div_mode()    : divisor -> operating mode
// ---------------------------------------------------------------------------
package clk_div_pkg;

  localparam int          DEFAULT_WIDTH = 16;
  localparam logic [31:0] DIV_STOP      = 32'd0;
  localparam logic [31:0] DIV_TICK      = 32'd1;

  typedef enum logic [1:0] {
    MODE_STOP = 2'd0,
    MODE_TICK = 2'd1,
    MODE_DIV  = 2'd2
  } ch_mode_e;

  // ceil(d/2) without needing a wider adder than the divisor itself
  function automatic logic [31:0] half_period(input logic [31:0] d);
    return (d >> 1) + {31'b0, d[0]};
  endfunction

  function automatic ch_mode_e div_mode(input logic [31:0] d);
    if (d == DIV_STOP) return MODE_STOP;
    if (d == DIV_TICK) return MODE_TICK;
    return MODE_DIV;
  endfunction

endpackage

// File: rtl/clk_div_multi_if.sv
// ---------------------------------------------------------------------------
// clk_div_multi_if
// Control/status bundle of the multi-channel clock divider.
//   i_divisor : per-channel divisor, channel k at [k*WIDTH +: WIDTH]
//   i_load    : per-channel divisor capture strobe
//   i_sync    : restart all running channels in phase
//   o_clk     : divided clocks
//   o_tick    : one-cycle strobe at the start of each period
//   o_pending : a loaded divisor is waiting for its period boundary
//   o_active  : channel runs in divide mode (divisor >= 2)
// master drives the controls, slave is the divider.
// ---------------------------------------------------------------------------
interface clk_div_multi_if
  import clk_div_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int WIDTH = DEFAULT_WIDTH
) ();

  logic [N_CH*WIDTH-1:0] i_divisor;
  logic [N_CH-1:0]       i_load;
  logic                  i_sync;
  logic [N_CH-1:0]       o_clk;
  logic [N_CH-1:0]       o_tick;
  logic [N_CH-1:0]       o_pending;
  logic [N_CH-1:0]       o_active;

  modport master (
    output i_divisor, i_load, i_sync,
    input  o_clk, o_tick, o_pending, o_active
  );

  modport slave (
    input  i_divisor, i_load, i_sync,
    output o_clk, o_tick, o_pending, o_active
  );

endinterface

// File: rtl/clk_div_ch.sv
// ---------------------------------------------------------------------------
// clk_div_ch
// One divider channel: shadowed divisor, period counter, posedge/negedge
// output flops. 50 % duty for even and odd divisors.
//   i_clk     : source clock (both edges used)
//   i_rst     : synchronous active-high reset
//   i_divisor : divisor presented for capture
//   i_load    : capture i_divisor (applied at the next period boundary)
//   i_sync    : force a period boundary now
//   o_clk     : divided clock
//   o_tick    : one-cycle strobe at each period start (every cycle in tick mode)
//   o_pending : loaded divisor waiting to be applied
//   o_active  : divisor in force is >= 2
// ---------------------------------------------------------------------------
module clk_div_ch
  import clk_div_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_divisor,
  input  logic             i_load,
  input  logic             i_sync,
  output logic             o_clk,
  output logic             o_tick,
  output logic             o_pending,
  output logic             o_active
);

  logic [WIDTH-1:0] cur, cur_n;
  logic [WIDTH-1:0] pend, pend_n;
  logic [WIDTH-1:0] cnt, cnt_n;
  logic             pend_v, pend_v_n;
  logic             pos_q, pos_n;
  logic             neg_q;
  logic             tick_q, tick_n;
  logic             running, wrap, boundary;
  ch_mode_e         mode_q, mode_n;

  // A channel that is stopped or in tick mode has no period to finish, so
  // every edge counts as a boundary and a load takes effect immediately.
  // A load on a boundary edge wins over an older pending value.
  always_comb begin
    running  = (mode_q == MODE_DIV);
    wrap     = running && (cnt == cur - WIDTH'(1));
    boundary = !running || wrap || i_sync;

    cur_n    = cur;
    pend_n   = pend;
    pend_v_n = pend_v;
    cnt_n    = '0;

    if (boundary && i_load) begin
      cur_n    = i_divisor;
      pend_v_n = 1'b0;
    end else if (boundary && pend_v) begin
      cur_n    = pend;
      pend_v_n = 1'b0;
    end else begin
      if (i_load) begin
        pend_n   = i_divisor;
        pend_v_n = 1'b1;
      end
      if (running && !wrap && !i_sync) begin
        cnt_n = cnt + WIDTH'(1);
      end
    end

    mode_n = div_mode(32'(cur_n));
    pos_n  = (mode_n == MODE_DIV) && (32'(cnt_n) < half_period(32'(cur_n)));
    tick_n = (mode_n == MODE_TICK) || ((mode_n == MODE_DIV) && (cnt_n == '0));
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cur    <= '0;
      pend   <= '0;
      pend_v <= 1'b0;
      cnt    <= '0;
      pos_q  <= 1'b0;
      tick_q <= 1'b0;
      mode_q <= MODE_STOP;
    end else begin
      cur    <= cur_n;
      pend   <= pend_n;
      pend_v <= pend_v_n;
      cnt    <= cnt_n;
      pos_q  <= pos_n;
      tick_q <= tick_n;
      mode_q <= mode_n;
    end
  end

  // Half-cycle delayed copy: ANDed with pos_q it trims half a cycle off the
  // high phase for odd divisors. Clears naturally the negedge after reset.
  always_ff @(negedge i_clk) begin
    neg_q <= pos_q;
  end

  // cur[0] only changes on a posedge, while neg_q is stable
  assign o_clk     = cur[0] ? (pos_q & neg_q) : pos_q;
  assign o_tick    = tick_q;
  assign o_pending = pend_v;
  assign o_active  = (mode_q == MODE_DIV);

endmodule

// File: rtl/clk_div_multi.sv
// ---------------------------------------------------------------------------
// clk_div_multi
// N_CH independent programmable clock dividers sharing one source clock.
//   i_clk : source clock (both edges used)
//   i_rst : synchronous active-high reset
//   bus   : clk_div_multi_if slave (divisors, loads, sync, clocks, ticks,
//           pending and active flags)
// ---------------------------------------------------------------------------
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic            i_clk,
  input  logic            i_rst,
  clk_div_multi_if.slave  bus
);

  logic [N_CH-1:0] ch_clk;
  logic [N_CH-1:0] ch_tick;
  logic [N_CH-1:0] ch_pending;
  logic [N_CH-1:0] ch_active;

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    clk_div_ch #(
      .WIDTH (WIDTH)
    ) u_ch (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_divisor (bus.i_divisor[k*WIDTH +: WIDTH]),
      .i_load    (bus.i_load[k]),
      .i_sync    (bus.i_sync),
      .o_clk     (ch_clk[k]),
      .o_tick    (ch_tick[k]),
      .o_pending (ch_pending[k]),
      .o_active  (ch_active[k])
    );
  end

  assign bus.o_clk     = ch_clk;
  assign bus.o_tick    = ch_tick;
  assign bus.o_pending = ch_pending;
  assign bus.o_active  = ch_active;

endmodule

// File: tb/tb_clk_div_multi.sv
// ---------------------------------------------------------------------------
// tb_clk_div_multi
// Self-checking bench for clk_div_multi. A period-based reference model
// (each channel remembers the edge its current period started on and derives
// its phase by modulo arithmetic) is compared against the DUT every cycle,
// in both halves of the clock. Directed scenarios add literal expectations.
// ---------------------------------------------------------------------------
module tb_clk_div_multi;

  localparam int N_CH  = 4;
  localparam int WIDTH = 16;
  localparam int DW    = N_CH * WIDTH;

  logic i_clk = 1'b0;
  logic i_rst;

  clk_div_multi_if #(.N_CH(N_CH), .WIDTH(WIDTH)) bus ();

  clk_div_multi #(
    .N_CH  (N_CH),
    .WIDTH (WIDTH)
  ) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus)
  );

  initial forever #5 i_clk = ~i_clk;

  int nChecks = 0;
  int nFails  = 0;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model state
  int mCur   [N_CH];
  int mPend  [N_CH];
  int mStart [N_CH];
  bit mPendV [N_CH];
  bit mHi    [N_CH];
  bit mHiPrev[N_CH];
  int cyc = 0;

  always begin : compareProc
    logic            rstS, syncS;
    logic [N_CH-1:0] loadS;
    logic [DW-1:0]   divS;
    logic [N_CH-1:0] eTick, ePend, eAct, eClk1, eClk2;
    int              d, ph;
    bit              bnd;

    @(posedge i_clk);
    rstS  = i_rst;
    syncS = bus.i_sync;
    loadS = bus.i_load;
    divS  = bus.i_divisor;
    cyc++;

    for (int k = 0; k < N_CH; k++) begin
      d = int'(divS[k*WIDTH +: WIDTH]);
      mHiPrev[k] = mHi[k];
      if (rstS) begin
        mCur[k]   = 0;
        mPend[k]  = 0;
        mPendV[k] = 1'b0;
        mStart[k] = cyc;
        mHi[k]    = 1'b0;
        eTick[k]  = 1'b0;
      end else begin
        if (mCur[k] < 2 || syncS) bnd = 1'b1;
        else bnd = ((cyc - mStart[k]) % mCur[k]) == 0;

        if (loadS[k] && bnd) begin
          mCur[k]   = d;
          mStart[k] = cyc;
          mPendV[k] = 1'b0;
        end else if (mPendV[k] && bnd) begin
          mCur[k]   = mPend[k];
          mStart[k] = cyc;
          mPendV[k] = 1'b0;
        end else begin
          if (loadS[k]) begin
            mPend[k]  = d;
            mPendV[k] = 1'b1;
          end
          if (syncS) mStart[k] = cyc;
        end

        if (mCur[k] >= 2) begin
          ph       = (cyc - mStart[k]) % mCur[k];
          eTick[k] = (ph == 0);
          mHi[k]   = ph < (mCur[k] + 1) / 2;
        end else begin
          eTick[k] = (mCur[k] == 1);
          mHi[k]   = 1'b0;
        end
      end
      eClk1[k] = (mCur[k] % 2 == 1) ? (mHi[k] && mHiPrev[k]) : mHi[k];
      eClk2[k] = mHi[k];
      ePend[k] = mPendV[k];
      eAct[k]  = (mCur[k] >= 2);
    end

    #2;
    checkOutput("o_tick", 64'(bus.o_tick), 64'(eTick));
    checkOutput("o_pending", 64'(bus.o_pending), 64'(ePend));
    checkOutput("o_active", 64'(bus.o_active), 64'(eAct));
    checkOutput("o_clk_first_half", 64'(bus.o_clk), 64'(eClk1));
    @(negedge i_clk);
    #1;
    checkOutput("o_clk_second_half", 64'(bus.o_clk), 64'(eClk2));
  end

  // Samples of the outputs taken in the second half of the previous cycle
  logic [N_CH-1:0] sClk, sTick, sPend, sAct;
  logic [DW-1:0]   divReg;

  function automatic logic [DW-1:0] withDiv(input logic [DW-1:0] base, input int ch,
                                            input int val);
    logic [DW-1:0] r;
    r = base;
    r[ch*WIDTH +: WIDTH] = WIDTH'(val);
    return r;
  endfunction

  task automatic applyStimulus(input logic rst, input logic [N_CH-1:0] load,
                               input logic [DW-1:0] div, input logic sync);
    @(negedge i_clk);
    #2;
    sClk  = bus.o_clk;
    sTick = bus.o_tick;
    sPend = bus.o_pending;
    sAct  = bus.o_active;
    i_rst         = rst;
    bus.i_load    = load;
    bus.i_divisor = div;
    bus.i_sync    = sync;
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0, '0, divReg, 1'b0);
  endtask

  initial begin : stimulus
    int ticks, high, pend, n, g;
    logic [N_CH-1:0] rload;
    logic [DW-1:0]   rdiv;
    int r, val;

    i_rst         = 1'b1;
    bus.i_load    = '0;
    bus.i_divisor = '0;
    bus.i_sync    = 1'b0;
    divReg        = '0;

    $display("[TB] reset");
    applyStimulus(1'b1, '0, divReg, 1'b0);
    applyStimulus(1'b0, '0, divReg, 1'b0);
    checkOutput("reset_clk", 64'(sClk), 64'd0);
    checkOutput("reset_tick", 64'(sTick), 64'd0);
    checkOutput("reset_pending", 64'(sPend), 64'd0);
    checkOutput("reset_active", 64'(sAct), 64'd0);

    $display("[TB] divisor 4 on channel 0");
    divReg = withDiv(divReg, 0, 4);
    applyStimulus(1'b0, 4'b0001, divReg, 1'b0);
    ticks = 0; high = 0;
    for (int i = 0; i < 8; i++) begin
      idle(1);
      if (i == 0) checkOutput("div4_first_tick", 64'(sTick[0]), 64'd1);
      ticks += int'(sTick[0]);
      high  += int'(sClk[0]);
    end
    checkOutput("div4_ticks_in_8", 64'(ticks), 64'd2);
    checkOutput("div4_high_in_8", 64'(high), 64'd4);

    $display("[TB] divisor 3 on channel 1");
    divReg = withDiv(divReg, 1, 3);
    applyStimulus(1'b0, 4'b0010, divReg, 1'b0);
    ticks = 0; high = 0;
    for (int i = 0; i < 6; i++) begin
      idle(1);
      ticks += int'(sTick[1]);
      high  += int'(sClk[1]);
    end
    checkOutput("div3_ticks_in_6", 64'(ticks), 64'd2);
    checkOutput("div3_high_in_6", 64'(high), 64'd4);

    $display("[TB] channel 2 at 8, load 5 at phase 2");
    divReg = withDiv(divReg, 2, 8);
    applyStimulus(1'b0, 4'b0100, divReg, 1'b0);
    idle(1);
    divReg = withDiv(divReg, 2, 5);
    applyStimulus(1'b0, 4'b0100, divReg, 1'b0);
    ticks = 0; pend = 0;
    for (int i = 0; i < 12; i++) begin
      idle(1);
      ticks += int'(sTick[2]);
      pend  += int'(sPend[2]);
    end
    checkOutput("shadow_pending_cycles", 64'(pend), 64'd6);
    checkOutput("shadow_ticks_in_12", 64'(ticks), 64'd2);

    $display("[TB] back-to-back loads 6 then 10");
    divReg = withDiv(divReg, 2, 6);
    applyStimulus(1'b0, 4'b0100, divReg, 1'b0);
    divReg = withDiv(divReg, 2, 10);
    applyStimulus(1'b0, 4'b0100, divReg, 1'b0);
    n = 0;
    do begin
      idle(1);
      n++;
    end while (sPend[2] && n < 40);
    checkOutput("latest_load_pending_clear", 64'(sPend[2]), 64'd0);
    checkOutput("latest_load_boundary_tick", 64'(sTick[2]), 64'd1);
    g = 0;
    do begin
      idle(1);
      g++;
    end while (!sTick[2] && g < 100);
    checkOutput("latest_load_period", 64'(g), 64'd10);

    $display("[TB] sync with channels at 3, 4, 10, 7");
    divReg = withDiv(divReg, 0, 3);
    divReg = withDiv(divReg, 1, 4);
    divReg = withDiv(divReg, 3, 7);
    applyStimulus(1'b0, 4'b1011, divReg, 1'b1);
    idle(1);
    checkOutput("sync_load_ticks", 64'(sTick), 64'b1111);
    idle(12);
    checkOutput("sync_plus12_ticks", 64'(sTick), 64'b0011);
    applyStimulus(1'b0, '0, divReg, 1'b1);
    idle(1);
    checkOutput("sync_only_ticks", 64'(sTick), 64'b1111);

    $display("[TB] tick-only then stop on channel 0");
    divReg = withDiv(divReg, 0, 1);
    applyStimulus(1'b0, 4'b0001, divReg, 1'b0);
    idle(4);
    for (int i = 0; i < 3; i++) begin
      idle(1);
      checkOutput("tick_mode_tick_clk_act", 64'({sTick[0], sClk[0], sAct[0]}), 64'b100);
    end
    divReg = withDiv(divReg, 0, 0);
    applyStimulus(1'b0, 4'b0001, divReg, 1'b0);
    idle(1);
    checkOutput("stop_mode_outputs", 64'({sTick[0], sClk[0], sAct[0], sPend[0]}), 64'd0);

    $display("[TB] maximum divisor on channel 1");
    divReg = withDiv(divReg, 1, 65535);
    applyStimulus(1'b0, 4'b0010, divReg, 1'b0);
    idle(20);
    checkOutput("max_div_active_pending", 64'({sAct[1], sPend[1]}), 64'b10);

    $display("[TB] reset mid-period on a divisor-5 channel");
    divReg = withDiv(divReg, 3, 5);
    applyStimulus(1'b0, 4'b1000, divReg, 1'b1);
    idle(1);
    divReg = withDiv(divReg, 2, 7);
    applyStimulus(1'b0, 4'b0100, divReg, 1'b0);
    applyStimulus(1'b1, 4'b1111, divReg, 1'b1);
    idle(1);
    checkOutput("midreset_clk", 64'(sClk), 64'd0);
    checkOutput("midreset_tick", 64'(sTick), 64'd0);
    checkOutput("midreset_pending", 64'(sPend), 64'd0);
    checkOutput("midreset_active", 64'(sAct), 64'd0);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 3000; i++) begin
      rload = ($urandom_range(0, 7) == 0) ? N_CH'($urandom) : '0;
      rdiv  = '0;
      for (int k = 0; k < N_CH; k++) begin
        r = int'($urandom_range(0, 15));
        if (r < 13) val = r;
        else if (r == 13) val = 65535;
        else val = int'($urandom_range(2, 40));
        rdiv = withDiv(rdiv, k, val);
      end
      applyStimulus($urandom_range(0, 399) == 0, rload, rdiv, $urandom_range(0, 49) == 0);
    end
    divReg = rdiv;
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
